// File: rtl/rf_pkg.sv
// Shared constants, op encodings and FSM states for the register-file burst master.
// Imported by rf_burst_master and rf_out_buf.
package rf_pkg;

    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 8;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;

    // A burst never touches more words than the register file holds.
    function automatic logic [3:0] clampCount(input logic [3:0] c);
        return (c > 4'(NUM_REGS)) ? 4'(NUM_REGS) : c;
    endfunction

endpackage

// File: rtl/rf_out_buf.sv
// One-entry valid/ready output register for the read stream.
// Flush discards the held word; reset also clears the data.
module rf_out_buf #(
    parameter int DATA_W = rf_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    // Load wins over a same-cycle handshake so back-to-back words stream at full rate.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/rf_burst_master.sv
// Burst initiator for the 8 x 32-bit register file: streams write data into
// the write port or read-port data out through a one-entry buffer.
module rf_burst_master #(
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int DATA_W = rf_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              op_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [3:0]        count_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] rf_wAddr_o,
    output logic [DATA_W-1:0] rf_wData_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_rAddr_o,
    input  logic [DATA_W-1:0] rf_rData_i
);

    import rf_pkg::*;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        remaining_q;

    logic inWrite;
    logic inRead;
    logic rdLoad_d;
    logic rdDrained_d;
    logic bufFlush_d;

    assign inWrite = (state_q == WRITE);
    assign inRead  = (state_q == READ);

    // Abort suppresses any access in the cycle it is raised.
    assign rdLoad_d    = inRead && !abort_i && (remaining_q != 4'd0) && (!out_valid_o || out_ready_i);
    assign rdDrained_d = (remaining_q == 4'd0) && (!out_valid_o || out_ready_i);
    assign bufFlush_d  = inRead && abort_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        addr_q      <= base_addr_i;
                        remaining_q <= clampCount(count_i);
                        if (count_i == 4'd0) begin
                            state_q <= DONE;
                        end else if (op_i == OP_READ) begin
                            state_q <= READ;
                        end else begin
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                    end else if (in_valid_i) begin
                        addr_q      <= addr_q + 1'b1;
                        remaining_q <= remaining_q - 4'd1;
                        if (remaining_q == 4'd1) begin
                            state_q <= DONE;
                        end
                    end
                end
                READ: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                    end else begin
                        if (rdLoad_d) begin
                            addr_q      <= addr_q + 1'b1;
                            remaining_q <= remaining_q - 4'd1;
                        end
                        if (rdDrained_d) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign in_ready_o = inWrite;
    assign rf_we_o    = inWrite && in_valid_i && !abort_i;
    assign rf_wAddr_o = addr_q;
    assign rf_wData_o = in_data_i;
    assign rf_rAddr_o = addr_q;

    rf_out_buf #(
        .DATA_W(DATA_W)
    ) u_out_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (bufFlush_d),
        .load_i  (rdLoad_d),
        .data_i  (rf_rData_i),
        .ready_i (out_ready_i),
        .valid_o (out_valid_o),
        .data_o  (out_data_o)
    );

endmodule

// File: tb/tb_rf_burst_master.sv
// Scoreboard bench for rf_burst_master: a behavioural register-file model predicts
// every write and every read-stream word; a monitor pops and compares them.
module tb_rf_burst_master;

    import rf_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        op_i;
    logic [2:0]  base_addr_i;
    logic [3:0]  count_i;
    logic        abort_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [2:0]  rf_wAddr_o;
    logic [31:0] rf_wData_o;
    logic        rf_we_o;
    logic [2:0]  rf_rAddr_o;
    logic [31:0] rf_rData_i;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         expWrQ[$];
    logic [31:0] expRdQ[$];
    logic [31:0] rfMem  [NUM_REGS];
    logic [31:0] refMem [NUM_REGS];
    logic [31:0] wrData [NUM_REGS];
    int          checks   = 0;
    int          failures = 0;
    bit          prevStall = 1'b0;
    logic [31:0] prevData  = '0;

    always #5 clk_i = ~clk_i;

    rf_burst_master dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .op_i        (op_i),
        .base_addr_i (base_addr_i),
        .count_i     (count_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .rf_wAddr_o  (rf_wAddr_o),
        .rf_wData_o  (rf_wData_o),
        .rf_we_o     (rf_we_o),
        .rf_rAddr_o  (rf_rAddr_o),
        .rf_rData_i  (rf_rData_i)
    );

    // The register file itself lives in the bench environment.
    always @(posedge clk_i) begin
        if (rf_we_o) rfMem[rf_wAddr_o] <= rf_wData_o;
    end
    assign rf_rData_i = rfMem[rf_rAddr_o];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    // Monitor: every write and every read-stream handshake must match the next prediction.
    always @(negedge clk_i) begin
        if (rst_i) begin
            prevStall = 1'b0;
        end else begin
            if (rf_we_o) begin
                if (expWrQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_write actual=addr %0d data 0x%h expected=no write", rf_wAddr_o, rf_wData_o);
                end else begin
                    wr_t e;
                    e = expWrQ.pop_front();
                    checkOutput("wr_addr", 32'(rf_wAddr_o), 32'(e.addr));
                    checkOutput("wr_data", rf_wData_o, e.data);
                end
            end
            if (prevStall) begin
                checkOutput("stall_hold_valid", 32'(out_valid_o), 32'd1);
                checkOutput("stall_hold_data", out_data_o, prevData);
            end
            if (out_valid_o && out_ready_i) begin
                if (expRdQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_read_word actual=0x%h expected=no word", out_data_o);
                end else begin
                    checkOutput("rd_data", out_data_o, expRdQ.pop_front());
                end
            end
            prevStall = out_valid_o && !out_ready_i;
            prevData  = out_data_o;
        end
    end

    // Issue one burst, predicting its writes / read words from refMem, then drive
    // the stream until done (or the abort cycle). readyMode -1 = pattern 1,0,0,1.
    task automatic applyStimulus(input logic op, input int base, input int cnt,
                                 input int validPct, input int readyMode,
                                 input int abortAt, input bit stray);
        int  eff;
        int  nWr;
        int  idx;
        int  cyc;
        int  doneCyc;
        int  expLat;
        bit  gotDone;
        bit  hs;
        bit  pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        eff = (cnt > NUM_REGS) ? NUM_REGS : cnt;
        if (op == OP_WRITE) begin
            nWr = (abortAt >= 0) ? abortAt : eff;
            for (int i = 0; i < nWr; i++) begin
                expWrQ.push_back('{addr: 3'((base + i) % NUM_REGS), data: wrData[i]});
                refMem[(base + i) % NUM_REGS] = wrData[i];
            end
        end else begin
            for (int i = 0; i < eff; i++) expRdQ.push_back(refMem[(base + i) % NUM_REGS]);
        end
        if (eff == 0)               expLat = 1;
        else if (op == OP_WRITE)    expLat = (validPct == 100) ? eff + 1 : 0;
        else                        expLat = (readyMode == 100) ? eff + 2 : 0;

        start_i = 1'b1; op_i = op; base_addr_i = 3'(base); count_i = 4'(cnt);
        in_valid_i = 1'b0; out_ready_i = 1'b1; abort_i = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        idx = 0; cyc = 1; gotDone = 1'b0; doneCyc = 0;
        while (!gotDone && cyc <= 80) begin
            if (stray && cyc == 2) begin
                start_i = 1'b1; op_i = ~op; base_addr_i = 3'(base + 3); count_i = 4'd5;
            end else begin
                start_i = 1'b0;
            end
            if (op == OP_WRITE) begin
                in_valid_i = ($urandom_range(99) < validPct);
                in_data_i  = (idx < NUM_REGS) ? wrData[idx] : $urandom;
                out_ready_i = 1'b1;
            end else begin
                in_valid_i  = 1'b0;
                out_ready_i = (readyMode < 0) ? pat[(cyc - 1) % 4] : ($urandom_range(99) < readyMode);
            end
            if (abortAt >= 0 && idx == abortAt) begin
                abort_i = 1'b1; in_valid_i = 1'b1;
                @(negedge clk_i);
                @(posedge clk_i); #1;
                abort_i = 1'b0; in_valid_i = 1'b0;
                checkOutput("abort_busy_next", 32'(busy_o), 32'd0);
                break;
            end
            @(negedge clk_i);
            if (done_o) begin
                gotDone = 1'b1;
                doneCyc = cyc;
            end
            if (op == OP_READ && readyMode == 100 && cyc <= eff)
                checkOutput("rd_addr", 32'(rf_rAddr_o), 32'((base + cyc - 1) % NUM_REGS));
            hs = in_valid_i && in_ready_o;
            @(posedge clk_i); #1;
            if (hs) idx++;
            cyc++;
        end
        start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1; abort_i = 1'b0;
        checkOutput("done_seen", 32'(gotDone), (abortAt >= 0) ? 32'd0 : 32'd1);
        if (abortAt < 0 && expLat > 0) checkOutput("done_latency", 32'(doneCyc), 32'(expLat));
        checkOutput("idle_busy", 32'(busy_o), 32'd0);
        checkOutput("done_one_cycle", 32'(done_o), 32'd0);
        checkOutput("wr_queue_drained", 32'(expWrQ.size()), 32'd0);
        checkOutput("rd_queue_drained", 32'(expRdQ.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b0; op_i = OP_WRITE; base_addr_i = '0; count_i = '0;
        abort_i = 1'b0; in_data_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) refMem[i] = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_done", 32'(done_o), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready_o), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
        checkOutput("rst_out_data", out_data_o, 32'd0);
        checkOutput("rst_we", 32'(rf_we_o), 32'd0);
        checkOutput("rst_wAddr", 32'(rf_wAddr_o), 32'd0);
        checkOutput("rst_rAddr", 32'(rf_rAddr_o), 32'd0);

        $display("[TB] write fill then read back");
        for (int i = 0; i < NUM_REGS; i++) wrData[i] = 32'h0123_4567 + 32'(i) * 32'h1111_1111;
        applyStimulus(OP_WRITE, 0, 8, 100, 100, -1, 1'b0);
        applyStimulus(OP_READ, 0, 8, 100, 100, -1, 1'b0);

        $display("[TB] wrap read");
        wrData[0] = 32'h6789_abcd; wrData[1] = 32'h789a_bcde;
        wrData[2] = 32'h0123_4567; wrData[3] = 32'h1234_5678;
        applyStimulus(OP_WRITE, 6, 4, 100, 100, -1, 1'b0);
        applyStimulus(OP_READ, 6, 4, 100, 100, -1, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(OP_READ, 2, 8, 100, -1, -1, 1'b0);
        for (int i = 0; i < NUM_REGS; i++) wrData[i] = $urandom;
        applyStimulus(OP_WRITE, 3, 6, 50, 100, -1, 1'b0);

        $display("[TB] count edge cases and ignored start");
        applyStimulus(OP_WRITE, 5, 0, 100, 100, -1, 1'b0);
        applyStimulus(OP_READ, 5, 0, 100, 100, -1, 1'b0);
        for (int i = 0; i < NUM_REGS; i++) wrData[i] = $urandom;
        applyStimulus(OP_WRITE, 4, 12, 100, 100, -1, 1'b1);
        applyStimulus(OP_READ, 1, 12, 100, 100, -1, 1'b1);

        $display("[TB] abort on third write");
        for (int i = 0; i < NUM_REGS; i++) wrData[i] = $urandom;
        applyStimulus(OP_WRITE, 0, 8, 100, 100, 2, 1'b0);
        applyStimulus(OP_READ, 0, 8, 100, 100, -1, 1'b0);

        $display("[TB] reset mid-read");
        start_i = 1'b1; op_i = OP_READ; base_addr_i = 3'd4; count_i = 4'd8; out_ready_i = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        checkOutput("pre_rst_out_valid", 32'(out_valid_o), 32'd1);
        rst_i = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy_o), 32'd0);
        checkOutput("mid_rst_done", 32'(done_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; out_ready_i = 1'b1;
        applyStimulus(OP_READ, 4, 8, 100, 100, -1, 1'b0);

        $display("[TB] randomized bursts");
        for (int n = 0; n < 30; n++) begin
            logic rop;
            rop = 1'($urandom_range(1));
            for (int i = 0; i < NUM_REGS; i++) wrData[i] = $urandom;
            applyStimulus(rop, int'($urandom_range(7)), int'($urandom_range(15)),
                          ($urandom_range(3) == 0) ? 100 : int'($urandom_range(100, 30)),
                          ($urandom_range(3) == 0) ? 100 : int'($urandom_range(100, 30)),
                          -1, 1'($urandom_range(1)));
        end

        repeat (3) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_burst_master.md
# rf_burst_master

Burst initiator for the 8 x 32-bit register file. It accepts a single command: write or read, a base address and a word count. It then sequences the register file's write port (wAddr/wData/we) or read port (rAddr/rData), one word per cycle. Write data arrives on a valid/ready input stream and read data leaves on a valid/ready output stream, so upstream logic can fill or dump the register file without driving its ports directly.

## Interface
- ADDR_W, 3, register address width (8 registers)
- DATA_W, 32, register data width
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- op  in  1  0 = write burst, 1 = read burst
- base_addr  in  ADDR_W  first register address
- count  in  4  words to transfer; 0 = no access; values above 8 are clamped to 8
- abort  in  1  synchronous cancel of the current burst
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at burst completion
- in_data  in  DATA_W  write-stream data
- in_valid  in  1  write-stream valid
- in_ready  out  1  write-stream ready
- out_data  out  DATA_W  read-stream data (registered)
- out_valid  out  1  read-stream valid (registered)
- out_ready  in  1  read-stream ready
- rf_wAddr  out  ADDR_W  register file write address
- rf_wData  out  DATA_W  register file write data
- rf_we  out  1  register file write enable
- rf_rAddr  out  ADDR_W  register file read address
- rf_rData  in  DATA_W  register file read data (combinational from rf_rAddr)

## Operation
- States: IDLE, WRITE, READ, DONE.
- Reset values: state IDLE, address counter 0, remaining count 0, busy 0, done 0, in_ready 0, out_valid 0, out_data 0, rf_we 0, rf_wAddr 0, rf_rAddr 0.
- IDLE: when start=1, latch base_addr into the address counter and latch min(count,8) into the remaining counter.
  - count=0 goes straight to DONE.
  - Otherwise op selects WRITE or READ.
- WRITE:
  - Combinational outputs: in_ready=1, rf_we=in_valid, rf_wAddr=addr, rf_wData=in_data.
  - On each in_valid handshake: addr+1 (mod 8) and remaining-1.
  - When remaining reaches 0, go to DONE.
- READ:
  - rf_rAddr = addr.
  - The output buffer loads rf_rData when remaining>0 and (out_valid=0 or out_ready=1). Each load advances addr by 1 (mod 8) and decrements remaining by 1.
  - Go to DONE when remaining=0 and the buffer has drained, i.e. the last word has been handshaken.
- DONE: done=1 for one cycle, then IDLE.
- Address wraps 7 -> 0. Example: base 6 with count 4 accesses 6, 7, 0, 1.
- start while busy is ignored.
- abort=1 in WRITE or READ: next state is IDLE.
  - No done pulse.
  - Buffered read word is dropped (out_valid=0).
  - Writes already performed stay written.
  - abort in IDLE or DONE has no effect.
- Asynchronous reset mid-burst: immediate return to reset values. The register file contents are not touched by this block.

## Timing
- start is accepted at edge T0, so the burst state begins in cycle 1.
- Write, N words, in_valid held high: writes land at edges T1..TN, DONE in cycle N+1, busy high in cycles 1..N+1.
- Read, N words, out_ready held high: out_valid high in cycles 2..N+1, done in cycle N+2. Sustained throughput is one word per cycle.
- Write backpressure: in_valid=0 stalls the burst with no write and no address change.
- Read backpressure: out_ready=0 holds out_data and out_valid stable, and rf_rAddr holds.
- At most one rf_we per cycle. rf_we is never asserted outside WRITE.

## Structure
- Package rf_pkg holds:
  - constants ADDR_W=3, DATA_W=32, NUM_REGS=8
  - op encodings OP_WRITE=0, OP_READ=1
  - FSM state enum {IDLE, WRITE, READ, DONE}
- One sub-module, rf_out_buf: a one-entry valid/ready output register with a load strobe and a flush on abort/reset.
- The register file itself is instantiated by the bench or top level, not inside this block.

## Test plan
- Write fill: op=0, base 0, count 8, in_data 0x0123_4567 + i*0x1111_1111 with in_valid always high -> rf_we high for 8 cycles at addresses 0..7, done in cycle 9; a read burst afterwards returns the same 8 words in order.
- Wrap read: preload regs 6, 7, 0, 1 with 0x6789_abcd, 0x789a_bcde, 0x0123_4567, 0x1234_5678; op=1, base 6, count 4 -> out_data sequence matches in order, rf_rAddr 6, 7, 0, 1, done in cycle 6.
- Backpressure: read with out_ready toggling 1, 0, 0, 1 -> out_data stable while stalled, no word lost or duplicated. Write with in_valid gaps -> exactly count writes.
- count=0 gives done in cycle 1 with no rf_we and no out_valid. count=12 is clamped to exactly 8 transfers.
- abort during the 3rd write of 8 -> 2 registers written, no done pulse, busy 0 the next cycle. start while busy is ignored.
- reset asserted mid-read with out_valid=1 -> out_valid, busy and done drop to 0 immediately; a new burst after reset runs normally.
